// File: rtl/key_pkg.sv
// Shared event codes and FSM state encoding for the key click classifier.
package key_pkg;

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SINGLE = 2'b01;
    localparam logic [1:0] EVT_DOUBLE = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WAIT2 = 1'b1
    } state_t;

endpackage

// File: rtl/key_sync_edge.sv
// Three-flop synchronizer with rising-edge detector for a slow, asynchronous
// key input. Produces one clk-cycle strobe per rising edge of din.
module key_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // sync3 is the previous value of the settled sample sync2.
    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/key_click_classifier.sv
// Classifies debounced key presses into single/double click events and
// presents them through a one-entry valid/ready output register.
// Optional feature macro: KEY_DOUBLE_CLICK_EN (defined: double-click
// detection with a DBL_WINDOW_CYC window; undefined: every press is SINGLE).
module key_click_classifier
    import key_pkg::*;
#(
    parameter int DBL_WINDOW_CYC = 30_000_000,
    parameter int CNT_W          = 32,
    parameter int DROP_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_pulse,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [1:0]        evt_code,
    output logic [DROP_W-1:0] drop_cnt
);

    // Reject configurations where the window counter cannot reach its last value.
    if (DBL_WINDOW_CYC < 2 || CNT_W < $clog2(DBL_WINDOW_CYC)) begin : g_cfg_check
        $error("key_click_classifier: DBL_WINDOW_CYC must be >= 2 and fit in CNT_W bits");
    end

    logic       press_stb;
    logic       emit;
    logic [1:0] emit_code;

    key_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (key_pulse),
        .rise (press_stb)
    );

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

`ifdef KEY_DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBL_WINDOW_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Click FSM state and window counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and event generation; a press at window expiry counts as double.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        emit      = 1'b0;
        emit_code = EVT_NONE;
        case (state)
            ST_IDLE: begin
                if (press_stb) begin
                    state_nxt = ST_WAIT2;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT2: begin
                if (press_stb) begin
                    emit      = 1'b1;
                    emit_code = EVT_DOUBLE;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    emit      = 1'b1;
                    emit_code = EVT_SINGLE;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
`else
    // Without double-click detection every press is a single click.
    always_comb begin
        emit      = press_stb;
        emit_code = press_stb ? EVT_SINGLE : EVT_NONE;
    end
`endif

    // Output register: load when empty or being drained, otherwise count a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_code  <= EVT_NONE;
            drop_cnt  <= '0;
        end else begin
            if (emit && (!evt_valid || evt_ready)) begin
                evt_valid <= 1'b1;
                evt_code  <= emit_code;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
                evt_code  <= EVT_NONE;
            end
            if (emit && evt_valid && !evt_ready) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_key_click_classifier.sv
// Self-checking bench for key_click_classifier. Works in both builds
// (KEY_DOUBLE_CLICK_EN defined or not); the reference model follows the macro.
module tb_key_click_classifier;
    import key_pkg::*;

    localparam int DBL      = 100;
    localparam int DROP_W   = 3;
    localparam int DROP_MAX = (1 << DROP_W) - 1;
`ifdef KEY_DOUBLE_CLICK_EN
    localparam bit DBL_EN = 1'b1;
`else
    localparam bit DBL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              key_pulse;
    logic              evt_ready;
    logic              evt_valid;
    logic [1:0]        evt_code;
    logic [DROP_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    key_click_classifier #(
        .DBL_WINDOW_CYC (DBL),
        .CNT_W          (8),
        .DROP_W         (DROP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_pulse (key_pulse),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .drop_cnt  (drop_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: edge count, press times, pending window, output slot.
    int         cyc;
    bit         prev_s;
    int         press_q[$];
    bit         pend;
    int         start;
    bit         m_valid;
    logic [1:0] m_code;
    int         m_drop;
    bit         press_now;
    bit         em;
    logic [1:0] ec;

    int dut_single = 0;
    int dut_double = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (model edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance the model across one rising clock edge using current inputs.
    task model_step();
        if (rst) begin
            cyc     = 0;
            prev_s  = 1'b0;
            press_q.delete();
            pend    = 1'b0;
            start   = 0;
            m_valid = 1'b0;
            m_code  = EVT_NONE;
            m_drop  = 0;
        end else begin
            cyc++;
            press_now = (press_q.size() > 0) && (press_q[0] == cyc);
            if (press_now) void'(press_q.pop_front());
            em = 1'b0;
            ec = EVT_NONE;
            if (DBL_EN) begin
                if (press_now) begin
                    if (pend) begin
                        em = 1'b1; ec = EVT_DOUBLE; pend = 1'b0;
                    end else begin
                        pend = 1'b1; start = cyc;
                    end
                end else if (pend && cyc == start + DBL) begin
                    em = 1'b1; ec = EVT_SINGLE; pend = 1'b0;
                end
            end else if (press_now) begin
                em = 1'b1; ec = EVT_SINGLE;
            end
            if (em && (!m_valid || evt_ready)) begin
                m_valid = 1'b1;
                m_code  = ec;
            end else begin
                if (em && m_drop < DROP_MAX) m_drop++;
                if (m_valid && evt_ready) begin
                    m_valid = 1'b0;
                    m_code  = EVT_NONE;
                end
            end
            // Key first sampled high at this edge registers as a press two edges later.
            if (key_pulse && !prev_s) press_q.push_back(cyc + 2);
            prev_s = key_pulse;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            if (!rst && evt_valid && evt_ready) begin
                if (evt_code == EVT_SINGLE) dut_single++;
                if (evt_code == EVT_DOUBLE) dut_double++;
            end
            model_step();
            @(posedge clk);
            @(negedge clk);
            chk("valid", evt_valid, m_valid);
            chk("code", evt_code, m_code);
            chk("drop", drop_cnt, m_drop);
        end
    endtask

    task automatic rtick(input int n);
        repeat (n) begin
            evt_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
    endtask

    task automatic press(input int len);
        key_pulse = 1'b1;
        tick(len);
        key_pulse = 1'b0;
    endtask

    int s0;
    int d0;

    initial begin
        rst       = 1'b1;
        key_pulse = 1'b0;
        evt_ready = 1'b1;
        @(negedge clk);
        tick(3);
        rst = 1'b0;

        // Idle after reset.
        tick(200);
        chk("idle_valid", evt_valid, 1'b0);
        chk("idle_code", evt_code, EVT_NONE);
        chk("idle_drop", drop_cnt, 0);

        // One long press, ready high.
        s0 = dut_single; d0 = dut_double;
`ifdef KEY_DOUBLE_CLICK_EN
        press(40);
        tick(62);
        chk("s1_before_window", evt_valid, 1'b0);
        tick(1);
        chk("s1_rise_valid", evt_valid, 1'b1);
        chk("s1_rise_code", evt_code, EVT_SINGLE);
        tick(1);
        chk("s1_after_accept", evt_valid, 1'b0);
`else
        key_pulse = 1'b1;
        tick(2);
        chk("s1_before_load", evt_valid, 1'b0);
        tick(1);
        chk("s1_rise_valid", evt_valid, 1'b1);
        chk("s1_rise_code", evt_code, EVT_SINGLE);
        tick(37);
        key_pulse = 1'b0;
`endif
        tick(200);
        chk("s1_singles", dut_single - s0, 1);
        chk("s1_doubles", dut_double - d0, 0);

        // Two presses 60 cycles apart.
        s0 = dut_single; d0 = dut_double;
        press(5); tick(55); press(5); tick(200);
        chk("gap60_doubles", dut_double - d0, DBL_EN ? 1 : 0);
        chk("gap60_singles", dut_single - s0, DBL_EN ? 0 : 2);

        // Two presses 100 cycles apart: second press lands on expiry.
        s0 = dut_single; d0 = dut_double;
        press(5); tick(95); press(5); tick(200);
        chk("gap100_doubles", dut_double - d0, DBL_EN ? 1 : 0);
        chk("gap100_singles", dut_single - s0, DBL_EN ? 0 : 2);

        // Two presses 101 cycles apart: window already closed.
        s0 = dut_single; d0 = dut_double;
        press(5); tick(96); press(5); tick(200);
        chk("gap101_doubles", dut_double - d0, 0);
        chk("gap101_singles", dut_single - s0, 2);

        // Back-pressure: three isolated presses with ready low.
        evt_ready = 1'b0;
        s0 = dut_single; d0 = dut_double;
        press(5); tick(145); press(5); tick(145); press(5); tick(150);
        chk("bp_held_valid", evt_valid, 1'b1);
        chk("bp_held_code", evt_code, EVT_SINGLE);
        chk("bp_drop", drop_cnt, 2);
        evt_ready = 1'b1;
        tick(1);
        chk("bp_drained", evt_valid, 1'b0);
        tick(5);
        chk("bp_singles", dut_single - s0, 1);

        // Reset in the middle of a pending window.
        s0 = dut_single; d0 = dut_double;
        press(5); tick(45);
        rst = 1'b1;
        tick(2);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        tick(3);
        press(5); tick(200);
        chk("rst_singles", dut_single - s0, DBL_EN ? 1 : 2);
        chk("rst_doubles", dut_double - d0, 0);

        // Drop counter saturation.
        evt_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            press(5); tick(145);
        end
        tick(60);
        chk("sat_drop", drop_cnt, DROP_MAX);
        chk("sat_valid", evt_valid, 1'b1);
        evt_ready = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);

        // Two presses 10 cycles apart.
        s0 = dut_single; d0 = dut_double;
        press(3); tick(7); press(3); tick(150);
        chk("gap10_singles", dut_single - s0, DBL_EN ? 0 : 2);
        chk("gap10_doubles", dut_double - d0, DBL_EN ? 1 : 0);

        // Random presses and random back-pressure against the model.
        for (int i = 0; i < 40; i++) begin
            key_pulse = 1'b1;
            rtick($urandom_range(1, 40));
            key_pulse = 1'b0;
            rtick($urandom_range(1, 220));
        end
        evt_ready = 1'b1;
        tick(250);
        chk("final_idle", evt_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
